// File: rtl/unidade_de_busca_pkg.sv
// Shared types and constants for the instruction fetch unit.
package unidade_de_busca_pkg;

  localparam int unsigned PC_W_DEF     = 32;
  localparam int unsigned RESET_PC_DEF = 0;
  localparam int unsigned JUMP_W       = 26;
  localparam int unsigned CNT_W        = 32;
  localparam int unsigned SEL_W        = 2;

  // Fetch unit control states
  typedef enum logic [1:0] {
    ST_RUN     = 2'b00,
    ST_WAIT_IN = 2'b01,
    ST_HALTED  = 2'b10
  } estado_t;

  // Next-PC selection codes from the control unit
  typedef enum logic [SEL_W-1:0] {
    PC_SEQ = 2'b00,
    PC_JF  = 2'b01,
    PC_JR  = 2'b10,
    PC_J   = 2'b11
  } pc_src_t;

endpackage

// File: rtl/unidade_de_busca_if.sv
// Control-unit <-> fetch-unit signal bundle.
interface unidade_de_busca_if
  import unidade_de_busca_pkg::*;
#(
  parameter int unsigned PC_W = PC_W_DEF
) ();

  logic [SEL_W-1:0]  pcSource;
  logic [JUMP_W-1:0] jumpAddr;
  logic [PC_W-1:0]   jrAddr;
  logic              isHalt;
  logic              isInsert;
  logic              confirmBtn;
  logic [PC_W-1:0]   pc;
  logic [PC_W-1:0]   pcPlusOne;
  logic              commit;
  logic              waiting;
  logic              halted;
  logic [CNT_W-1:0]  instrCount;

  modport master (
    output pcSource, jumpAddr, jrAddr, isHalt, isInsert, confirmBtn,
    input  pc, pcPlusOne, commit, waiting, halted, instrCount
  );

  modport slave (
    input  pcSource, jumpAddr, jrAddr, isHalt, isInsert, confirmBtn,
    output pc, pcPlusOne, commit, waiting, halted, instrCount
  );

endinterface

// File: rtl/unidade_de_busca_sincronizador_botao.sv
// Two-flop synchronizer for the operator button plus rising-edge detector.
module sincronizador_botao (
  input  logic clk,
  input  logic i_rst_n,
  input  logic i_btn,
  output logic o_edge
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  // Synchronizer chain and previous-sample flop
  always_ff @(posedge clk) begin
    if (!i_rst_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
      r_prev <= 1'b0;
    end else begin
      r_meta <= i_btn;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign o_edge = r_sync & ~r_prev;

endmodule

// File: rtl/unidade_de_busca.sv
// Instruction fetch unit: PC register, next-PC mux, run/wait/halt control.
module unidade_de_busca
  import unidade_de_busca_pkg::*;
#(
  parameter int unsigned     PC_W     = PC_W_DEF,
  parameter logic [PC_W-1:0] RESET_PC = PC_W'(RESET_PC_DEF)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rstBios,
  unidade_de_busca_if.slave bus
);

  estado_t          r_state;
  estado_t          w_state_next;
  logic [PC_W-1:0]  r_pc;
  logic [PC_W-1:0]  w_pc_inc;
  logic [PC_W-1:0]  w_pc_target;
  logic [CNT_W-1:0] r_count;
  logic             r_waiting;
  logic             r_halted;
  logic             w_commit;
  logic             w_edge;
  logic             w_sync_rst_n;
  pc_src_t          w_sel;

  // Either reset flavour clears the button synchronizer
  assign w_sync_rst_n = rst & ~rstBios;

  sincronizador_botao u_sincronizador (
    .clk     (clk),
    .i_rst_n (w_sync_rst_n),
    .i_btn   (bus.confirmBtn),
    .o_edge  (w_edge)
  );

  // Next-PC selection; pc+1 wraps naturally at PC_W bits
  always_comb begin
    w_pc_inc    = r_pc + PC_W'(1);
    w_sel       = pc_src_t'(bus.pcSource);
    w_pc_target = w_pc_inc;
    unique case (w_sel)
      PC_SEQ: w_pc_target = w_pc_inc;
      PC_JR:  w_pc_target = bus.jrAddr;
      PC_JF:  w_pc_target = PC_W'(bus.jumpAddr);
      PC_J:   w_pc_target = PC_W'(bus.jumpAddr);
    endcase
  end

  // Next-state and commit decode; a reset cycle never retires anything
  always_comb begin
    w_state_next = r_state;
    w_commit     = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (bus.isHalt)        w_state_next = ST_HALTED;
        else if (bus.isInsert) w_state_next = ST_WAIT_IN;
        else                   w_commit     = 1'b1;
      end
      ST_WAIT_IN: begin
        if (w_edge) begin
          w_commit     = 1'b1;
          w_state_next = ST_RUN;
        end
      end
      ST_HALTED: w_state_next = ST_HALTED;
      default:   w_state_next = ST_RUN;
    endcase
    if (!rst || rstBios) w_commit = 1'b0;
  end

  // State, PC, retire counter and status flags
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= ST_RUN;
      r_pc      <= RESET_PC;
      r_count   <= '0;
      r_waiting <= 1'b0;
      r_halted  <= 1'b0;
    end else if (rstBios) begin
      r_state   <= ST_RUN;
      r_pc      <= RESET_PC;
      r_waiting <= 1'b0;
      r_halted  <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_waiting <= (w_state_next == ST_WAIT_IN);
      r_halted  <= (w_state_next == ST_HALTED);
      if (w_commit) begin
        r_pc    <= w_pc_target;
        r_count <= r_count + CNT_W'(1);
      end
    end
  end

  assign bus.pc         = r_pc;
  assign bus.pcPlusOne  = w_pc_inc;
  assign bus.commit     = w_commit;
  assign bus.waiting    = r_waiting;
  assign bus.halted     = r_halted;
  assign bus.instrCount = r_count;

endmodule

// File: tb/tb_unidade_de_busca.sv
// Scoreboard bench for unidade_de_busca: each expected retirement is queued by
// the stimulus and checked by a monitor whenever commit is seen.
module tb_unidade_de_busca;

  logic clk;
  logic rst;
  logic rstBios;

  unidade_de_busca_if #(.PC_W(32)) bus ();

  unidade_de_busca #(.PC_W(32), .RESET_PC(32'h0)) dut (
    .clk     (clk),
    .rst     (rst),
    .rstBios (rstBios),
    .bus     (bus)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] cnt;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_err = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: every commit must match the oldest queued retirement
  always @(negedge clk) begin
    if (bus.commit === 1'b1) begin
      n_vec++;
      if (q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_commit: pc=%h cnt=%0d, required no commit", bus.pc, bus.instrCount);
      end else begin
        exp_t e;
        e = q.pop_front();
        if (bus.pc !== e.pc || bus.instrCount !== e.cnt) begin
          n_err++;
          $display("FAIL commit: pc=%h cnt=%0d, required pc=%h cnt=%0d",
                   bus.pc, bus.instrCount, e.pc, e.cnt);
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic expect_commit(input logic [31:0] pc, input logic [31:0] cnt);
    exp_t e;
    e.pc  = pc;
    e.cnt = cnt;
    q.push_back(e);
  endtask

  initial begin
    bit seen;
    rst = 1'b0; rstBios = 1'b0;
    bus.pcSource = 2'b00; bus.jumpAddr = '0; bus.jrAddr = '0;
    bus.isHalt = 1'b0; bus.isInsert = 1'b0; bus.confirmBtn = 1'b0;

    // Reset state
    step(2);
    chk("rst_pc", bus.pc, 32'h0);
    chk("rst_cnt", bus.instrCount, 32'h0);
    chk("rst_waiting", 32'(bus.waiting), 32'h0);
    chk("rst_halted", 32'(bus.halted), 32'h0);
    chk("rst_commit", 32'(bus.commit), 32'h0);

    // Sequential fetch
    for (int i = 0; i < 5; i++) expect_commit(32'(i), 32'(i));
    rst = 1'b1;
    step(5);
    chk("seq_pc", bus.pc, 32'h5);
    chk("seq_cnt", bus.instrCount, 32'h5);
    expect_commit(32'h5, 32'h5);
    expect_commit(32'h6, 32'h6);
    step(2);
    chk("seq_pc7", bus.pc, 32'h7);

    // Jumps
    bus.pcSource = 2'b11; bus.jumpAddr = 26'h0000040;
    expect_commit(32'h7, 32'h7);
    step(1);
    chk("j_pc", bus.pc, 32'h40);
    bus.pcSource = 2'b10; bus.jrAddr = 32'h123;
    expect_commit(32'h40, 32'h8);
    step(1);
    chk("jr_pc", bus.pc, 32'h123);
    chk("jr_plus1", bus.pcPlusOne, 32'h124);
    bus.pcSource = 2'b01; bus.jumpAddr = 26'h3FFFFFF;
    expect_commit(32'h123, 32'h9);
    step(1);
    chk("jf_zext", bus.pc, 32'h03FF_FFFF);
    bus.jumpAddr = 26'h3;
    expect_commit(32'h03FF_FFFF, 32'hA);
    step(1);
    chk("jf_pc3", bus.pc, 32'h3);
    chk("cnt11", bus.instrCount, 32'hB);

    // Wait for operator input
    bus.pcSource = 2'b00; bus.isInsert = 1'b1;
    step(11);
    chk("wait_pc", bus.pc, 32'h3);
    chk("wait_flag", 32'(bus.waiting), 32'h1);
    chk("wait_commit", 32'(bus.commit), 32'h0);
    chk("wait_cnt", bus.instrCount, 32'hB);
    bus.isInsert = 1'b0;
    bus.confirmBtn = 1'b1;
    expect_commit(32'h3, 32'hB);
    step(1);
    bus.confirmBtn = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (!seen) begin
        step(1);
        if (bus.waiting === 1'b0) seen = 1'b1;
      end
    end
    chk("btn_release", 32'(seen), 32'h1);
    chk("btn_pc", bus.pc, 32'h4);
    chk("btn_cnt", bus.instrCount, 32'hC);

    // Halt at pc=9
    bus.pcSource = 2'b01; bus.jumpAddr = 26'h9;
    expect_commit(32'h4, 32'hC);
    step(1);
    chk("pre_halt_pc", bus.pc, 32'h9);
    bus.isHalt = 1'b1;
    step(1);
    chk("halted", 32'(bus.halted), 32'h1);
    for (int i = 0; i < 20; i++) begin
      bus.confirmBtn = (i % 4 == 0);
      step(1);
      chk("halt_pc", bus.pc, 32'h9);
      chk("halt_flag", 32'(bus.halted), 32'h1);
    end
    bus.confirmBtn = 1'b0;

    // Soft reset keeps the retire counter
    rstBios = 1'b1; bus.isHalt = 1'b0; bus.pcSource = 2'b00;
    step(1);
    chk("bios_pc", bus.pc, 32'h0);
    chk("bios_halted", 32'(bus.halted), 32'h0);
    chk("bios_cnt", bus.instrCount, 32'hD);
    chk("bios_commit", 32'(bus.commit), 32'h0);

    // Button edge arriving in RUN is dropped
    bus.confirmBtn = 1'b1;
    expect_commit(32'h0, 32'hD);
    expect_commit(32'h1, 32'hE);
    expect_commit(32'h2, 32'hF);
    rstBios = 1'b0;
    step(1);
    bus.confirmBtn = 1'b0;
    step(2);
    bus.isInsert = 1'b1;
    step(6);
    chk("drop_waiting", 32'(bus.waiting), 32'h1);
    chk("drop_pc", bus.pc, 32'h3);
    chk("drop_cnt", bus.instrCount, 32'h10);

    // Hard reset during WAIT_IN with a live button edge
    bus.confirmBtn = 1'b1;
    step(1);
    bus.confirmBtn = 1'b0;
    step(1);
    rst = 1'b0;
    step(1);
    chk("rstwait_pc", bus.pc, 32'h0);
    chk("rstwait_cnt", bus.instrCount, 32'h0);
    chk("rstwait_waiting", 32'(bus.waiting), 32'h0);

    // PC wrap
    bus.isInsert = 1'b0; bus.pcSource = 2'b10; bus.jrAddr = 32'hFFFF_FFFF;
    expect_commit(32'h0, 32'h0);
    rst = 1'b1;
    step(1);
    chk("wrap_pre", bus.pc, 32'hFFFF_FFFF);
    chk("wrap_plus1", bus.pcPlusOne, 32'h0);
    bus.pcSource = 2'b00;
    expect_commit(32'hFFFF_FFFF, 32'h1);
    step(1);
    chk("wrap_pc", bus.pc, 32'h0);
    chk("wrap_cnt", bus.instrCount, 32'h2);
    bus.isHalt = 1'b1;
    step(2);

    chk("queue_drained", 32'(q.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
